// File: rtl/div_seq.sv
// Multi-cycle 32-bit restoring divider for DIV/DIVU: one quotient bit per clock,
// sign correction on the final edge, divide-by-zero shortcut and flush abort.
module div_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {IDLE, BYZERO, RUN, DONE} state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   // Working {R,Q}; the top bit of the 65-bit form is always zero, so it is not stored.
   logic [63:0] w_q, w_d;
   logic [31:0] d_q, d_d;
   logic        neg_quo_q, neg_quo_d;
   logic        neg_rem_q, neg_rem_d;
   logic [63:0] result_q, result_d;
   logic        ready_q, ready_d;

   logic [31:0] abs_a, abs_b, quo, rem;
   logic [32:0] diff;

   always_comb begin
      abs_a = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
      abs_b = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
      diff  = w_q[63:31] - {1'b0, d_q};
      quo   = neg_quo_q ? -w_q[31:0]  : w_q[31:0];
      rem   = neg_rem_q ? -w_q[63:32] : w_q[63:32];

      state_d   = state_q;
      cnt_d     = cnt_q;
      w_d       = w_q;
      d_d       = d_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;
      ready_d   = ready_q;

      case (state_q)
         IDLE: begin
            result_d = 64'h0;
            ready_d  = 1'b0;
            if (start_i && !annul_i) begin
               if (opdata2_i == 32'h0) begin
                  state_d = BYZERO;
               end else begin
                  d_d       = abs_b;
                  w_d       = {32'h0, abs_a};
                  neg_quo_d = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                  neg_rem_d = signed_div_i & opdata1_i[31];
                  cnt_d     = 6'd0;
                  state_d   = RUN;
               end
            end
         end
         BYZERO: begin
            result_d = 64'h0;
            ready_d  = !annul_i;
            state_d  = annul_i ? IDLE : DONE;
         end
         RUN: begin
            if (annul_i) begin
               result_d = 64'h0;
               ready_d  = 1'b0;
               state_d  = IDLE;
            end else if (cnt_q != 6'd32) begin
               // No borrow means the shifted remainder covers the divisor: subtract and set the quotient bit.
               if (!diff[32]) w_d = {diff[31:0], w_q[30:0], 1'b1};
               else           w_d = {w_q[62:0], 1'b0};
               cnt_d = cnt_q + 6'd1;
            end else begin
               result_d = {rem, quo};
               ready_d  = 1'b1;
               state_d  = DONE;
            end
         end
         DONE: begin
            if (!start_i) begin
               result_d = 64'h0;
               ready_d  = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= 6'd0;
         w_q       <= 64'h0;
         d_q       <= 32'h0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= 64'h0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         w_q       <= w_d;
         d_q       <= d_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
         ready_q   <= ready_d;
      end
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;
   assign busy_o   = (state_q == RUN) || (state_q == BYZERO);

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: expected {R,Q} pushed to a scoreboard on start,
// popped and compared when ready_o rises; latency, flush and reset are checked too.
module tb_div_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i, opdata2_i;
   logic        start_i, annul_i;
   logic [63:0] result_o;
   logic        ready_o, busy_o;

   int n_vec  = 0;
   int n_miss = 0;
   logic [63:0] exp_q[$];
   logic [63:0] last_exp;

   div_seq dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o),
      .busy_o       (busy_o)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'h0) return 64'h0;
      if (sg) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'h0, a});
         sb = longint'({32'h0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_div(input logic sg, input logic [31:0] a, input logic [31:0] b, input bit push);
      signed_div_i = sg;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      if (push) exp_q.push_back(model(sg, a, b));
   endtask

   // Counts edges from the start-sampling edge until ready_o is seen; optionally scrambles operands meanwhile.
   task automatic wait_ready(input int exp_lat, input bit scramble);
      int  n;
      bit  busy_ok = 1'b1;
      for (n = 1; n <= 60; n++) begin
         step();
         if (scramble) begin
            opdata1_i = $urandom;
            opdata2_i = $urandom;
         end
         if (ready_o === 1'b1) break;
         if (busy_o !== 1'b1) busy_ok = 1'b0;
      end
      check("latency", 64'(n), 64'(exp_lat));
      check("busy_while_running", {63'h0, busy_ok}, 64'h1);
      last_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
      check("result", result_o, last_exp);
   endtask

   task automatic release_start();
      start_i = 1'b0;
      step();
      check("ready_after_release", {63'h0, ready_o}, 64'h0);
      check("result_after_release", result_o, 64'h0);
   endtask

   task automatic expect_no_ready(input string tag, input int cycles);
      bit seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         step();
         if (ready_o !== 1'b0) seen = 1'b1;
      end
      check(tag, {63'h0, seen}, 64'h0);
   endtask

   initial begin
      rst = 1'b0; signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
      start_i = 1'b0; annul_i = 1'b0;
      step(); step();
      check("reset_result", result_o, 64'h0);
      check("reset_ready", {63'h0, ready_o}, 64'h0);
      check("reset_busy", {63'h0, busy_o}, 64'h0);
      rst = 1'b1;
      step();

      // Unsigned 100/7, then hold start for five cycles in DONE.
      start_div(1'b0, 32'd100, 32'd7, 1'b1);
      check("model_100_7", exp_q[0], {32'd2, 32'd14});
      wait_ready(34, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step();
         check("hold_ready", {63'h0, ready_o}, 64'h1);
         check("hold_result", result_o, last_exp);
      end
      release_start();

      start_div(1'b1, 32'hFFFFFFF9, 32'h00000002, 1'b1);
      wait_ready(34, 1'b0);
      check("neg7_div_2", result_o, {32'hFFFFFFFF, 32'hFFFFFFFD});
      release_start();

      start_div(1'b1, 32'h00000007, 32'hFFFFFFFE, 1'b1);
      wait_ready(34, 1'b0);
      check("7_div_neg2", result_o, {32'h00000001, 32'hFFFFFFFD});
      release_start();

      start_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1);
      wait_ready(34, 1'b0);
      check("min_div_neg1", result_o, {32'h0, 32'h80000000});
      release_start();

      start_div(1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b1);
      wait_ready(34, 1'b0);
      release_start();

      start_div(1'b1, 32'h12345678, 32'h0, 1'b1);
      wait_ready(2, 1'b0);
      check("byzero_ready", {63'h0, ready_o}, 64'h1);
      release_start();

      // Operands scrambled after the latch edge must not disturb the result.
      start_div(1'b0, 32'hDEADBEEF, 32'h00001234, 1'b1);
      wait_ready(34, 1'b1);
      release_start();

      for (int k = 0; k < 3; k++) begin
         start_div(1'b1, $urandom, $urandom_range(1, 32'h0000FFFF) | ((k == 1) ? 32'h80000000 : 32'h0), 1'b1);
         wait_ready(34, 1'b0);
         release_start();
      end

      // Flush at iteration 10, then a fresh 50/5.
      start_div(1'b0, 32'd1000, 32'd3, 1'b0);
      step();
      for (int i = 0; i < 10; i++) step();
      check("busy_before_annul", {63'h0, busy_o}, 64'h1);
      annul_i = 1'b1; start_i = 1'b0;
      step();
      annul_i = 1'b0;
      check("annul_busy", {63'h0, busy_o}, 64'h0);
      check("annul_result", result_o, 64'h0);
      expect_no_ready("annul_no_ready", 40);
      start_div(1'b0, 32'd50, 32'd5, 1'b1);
      wait_ready(34, 1'b0);
      check("50_div_5", result_o, {32'd0, 32'd10});
      release_start();

      // start together with annul in IDLE is refused.
      start_div(1'b0, 32'd9, 32'd3, 1'b0);
      annul_i = 1'b1;
      step(); step();
      check("start_annul_idle", {63'h0, busy_o}, 64'h0);
      start_i = 1'b0; annul_i = 1'b0;
      expect_no_ready("start_annul_no_ready", 5);

      // Reset mid-RUN.
      start_div(1'b0, 32'd12345, 32'd67, 1'b0);
      for (int i = 0; i < 16; i++) step();
      rst = 1'b0;
      step();
      check("rst_run_busy", {63'h0, busy_o}, 64'h0);
      check("rst_run_ready", {63'h0, ready_o}, 64'h0);
      check("rst_run_result", result_o, 64'h0);
      rst = 1'b1; start_i = 1'b0;
      expect_no_ready("rst_run_no_ready", 40);

      // Reset while holding in DONE.
      start_div(1'b0, 32'd77, 32'd10, 1'b1);
      wait_ready(34, 1'b0);
      rst = 1'b0;
      step();
      check("rst_done_ready", {63'h0, ready_o}, 64'h0);
      check("rst_done_result", result_o, 64'h0);
      rst = 1'b1; start_i = 1'b0;
      expect_no_ready("rst_done_no_ready", 5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle 32-bit integer divide sequencer for the MIPS32 execute stage. It serves DIV/DIVU: the execute stage asserts start with operands and holds its stall request until ready. The block then runs one restoring-division step per clock and returns {remainder, quotient} for the HI/LO write path. It owns the iteration counter, operand latching, sign correction, divide-by-zero handling and abort on pipeline flush.

## Interface
Parameters: none (width fixed at 32 by `RegBus`).

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge)
- signed_div_i  in  1  1 = DIV (two's complement), 0 = DIVU
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- start_i  in  1  request; held high by execute stage until result consumed
- annul_i  in  1  flush/abort of the in-flight divide
- result_o  out  64  {remainder[63:32], quotient[31:0]}, registered
- ready_o  out  1  result valid, registered
- busy_o  out  1  high in RUN and BYZERO (decoded from state)

## Operation
- States: IDLE, BYZERO, RUN, DONE. Registers: state, cnt[5:0], W[64:0] working {R,Q}, D[31:0] |divisor|, neg_q, neg_r, result_o, ready_o.
- IDLE: result_o=0, ready_o=0. If start_i=1 and annul_i=0:
  - divisor==0 -> BYZERO.
  - else latch operands, cnt<=0 -> RUN.
  - D<=|opdata2_i| and W<={33'b0,|opdata1_i|} when signed, raw values when unsigned.
  - neg_q<=signed & (op1[31]^op2[31]); neg_r<=signed & op1[31].
  - Operand changes after the latch edge are ignored.
- BYZERO: next edge -> DONE with result_o=64'h0, ready_o=1.
- RUN, cnt<32, one step per edge:
  - diff = W[63:31] - {1'b0,D} (33-bit).
  - If diff[32]==0: W<={diff[31:0],W[30:0],1'b1}, else W<={W[62:0],1'b0}.
  - cnt<=cnt+1.
- RUN, cnt==32, next edge -> DONE with ready_o<=1.
  - Quotient = neg_q ? -W[31:0] : W[31:0].
  - Remainder = neg_r ? -W[63:32] : W[63:32].
- DONE: hold result_o/ready_o while start_i=1. When start_i=0 -> IDLE, clearing result_o and ready_o on that edge.
- annul_i=1 in RUN or BYZERO -> IDLE next edge, ready_o stays 0, result_o=0. annul_i is ignored in DONE; start_i governs the exit.
- Signed 0x80000000 / 0xFFFFFFFF gives Q=0x80000000, R=0 (wraps, no trap).
- Remainder sign follows dividend. |R| < |divisor|.

## Timing
- Reset (rst=0 at edge): state=IDLE, cnt=0, W=0, result_o=0, ready_o=0, busy_o=0. This overrides any state, including mid-RUN and DONE.
- Nonzero divisor, start_i first sampled at edge of cycle T:
  - RUN from T+1.
  - 32 iteration edges at the ends of T+1..T+32.
  - Correction edge at the end of T+33.
  - ready_o=1 visible in cycle T+34.
- Divisor zero: BYZERO in T+1, ready_o=1 in T+2.
- busy_o is combinational from state. The execute stage forms its stall as start_i & ~ready_o.
- Back-to-back: after DONE, start_i must be low for at least one edge (return to IDLE) before a new divide is accepted.
- start_i=1 with annul_i=1 in IDLE: not accepted, stays IDLE.

## Test plan
- Unsigned 100/7, start held: ready_o rises exactly 34 cycles after start sampled. result_o = {32'd2, 32'd14}, busy_o high during cycles T+1..T+33.
- Signed -7/2 (0xFFFFFFF9/0x00000002): Q=0xFFFFFFFD, R=0xFFFFFFFF. Signed 7/-2: Q=0xFFFFFFFD, R=0x00000001.
- Signed 0x80000000/0xFFFFFFFF: Q=0x80000000, R=0. Unsigned 0xFFFFFFFF/1: Q=0xFFFFFFFF, R=0. Divisor 0: ready_o in T+2, result_o=0.
- annul_i pulsed at RUN iteration 10: IDLE next cycle, ready_o never rises. A fresh 50/5 started afterward yields Q=10, R=0 at the correct latency.
- rst=0 for one edge mid-RUN: all outputs 0 next cycle, state IDLE, no ready. rst=0 while in DONE clears result_o.
- Hold start_i high 5 cycles in DONE: result_o/ready_o stable. Drop start_i: both 0 next cycle. Operands changed during RUN do not alter the result.
